// File: rtl/parity_gen.sv
// parity_gen: registered even/odd parity, population count and running stream
// parity for words entering the link transmit path. One cycle latency, no stall.
// Optional receive-side checking (parity_in / parity_err / err_sticky) is
// compiled in when PARITY_GEN_CHECK_EN is defined.
module parity_gen #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              in_valid,
    input  logic              odd_sel,
    input  logic              acc_clear,
`ifdef PARITY_GEN_CHECK_EN
    input  logic              parity_in,
    output logic              parity_err,
    output logic              err_sticky,
`endif
    output logic [DATA_W-1:0] data_out,
    output logic              parity,
    output logic [CNT_W-1:0]  ones_count,
    output logic              out_valid,
    output logic              acc_parity
);

    // Single-stage pipeline: [0] is the incoming valid, [1] is the output valid.
    localparam int STAGES = 1;

    logic [STAGES:0]  vld_pipe;
    logic             par_next;
    logic [CNT_W-1:0] cnt_next;

    assign vld_pipe[0] = in_valid;
    assign out_valid   = vld_pipe[STAGES];

    // Parity of the incoming word; odd mode is simply the inverted XOR reduction.
    always_comb begin
        par_next = (^data_in) ^ odd_sel;
    end

    // Full population count; CNT_W is wide enough that all-ones does not wrap.
    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < DATA_W; i++) begin
            cnt_next = cnt_next + CNT_W'(data_in[i]);
        end
    end

    // Valid shift register; an in-flight word is dropped on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe[STAGES:1] <= '0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
        end
    end

    // Output word registers; hold their value through gaps in in_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= '0;
            parity     <= 1'b0;
            ones_count <= '0;
        end else if (in_valid) begin
            data_out   <= data_in;
            parity     <= par_next;
            ones_count <= cnt_next;
        end
    end

    // Running stream parity; a clear takes effect before the same-cycle word is folded in.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_parity <= 1'b0;
        end else if (acc_clear) begin
            acc_parity <= in_valid & par_next;
        end else if (in_valid) begin
            acc_parity <= acc_parity ^ par_next;
        end
    end

`ifdef PARITY_GEN_CHECK_EN
    logic err_next;

    // Received parity bit disagrees with the locally computed one.
    always_comb begin
        err_next = par_next ^ parity_in;
    end

    // Per-word error flag follows the same hold rules as parity.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else if (in_valid) begin
            parity_err <= err_next;
        end
    end

    // Sticky error: a new mismatch wins over a same-cycle acc_clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky <= 1'b0;
        end else if (in_valid && err_next) begin
            err_sticky <= 1'b1;
        end else if (acc_clear) begin
            err_sticky <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_parity_gen.sv
// Randomised + directed bench for parity_gen against a behavioural model
// built from $countones and simple per-word bookkeeping.
module tb_parity_gen;

    localparam int DATA_W = 8;
    localparam int CNT_W  = $clog2(DATA_W + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] data_in = '1;
    logic              in_valid = 1'b1;
    logic              odd_sel = 1'b0;
    logic              acc_clear = 1'b0;
    logic [DATA_W-1:0] data_out;
    logic              parity;
    logic [CNT_W-1:0]  ones_count;
    logic              out_valid;
    logic              acc_parity;
`ifdef PARITY_GEN_CHECK_EN
    logic              parity_in = 1'b0;
    logic              parity_err;
    logic              err_sticky;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [DATA_W-1:0] m_dout = '0;
    logic              m_par = 1'b0;
    int                m_cnt = 0;
    logic              m_vld = 1'b0;
    logic              m_acc = 1'b0;
    logic              m_err = 1'b0;
    logic              m_sticky = 1'b0;

    parity_gen #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .in_valid   (in_valid),
        .odd_sel    (odd_sel),
        .acc_clear  (acc_clear),
`ifdef PARITY_GEN_CHECK_EN
        .parity_in  (parity_in),
        .parity_err (parity_err),
        .err_sticky (err_sticky),
`endif
        .data_out   (data_out),
        .parity     (parity),
        .ones_count (ones_count),
        .out_valid  (out_valid),
        .acc_parity (acc_parity)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle, advance the model, compare every output.
    task automatic step(input logic r, input logic [DATA_W-1:0] d, input logic v,
                        input logic odd, input logic clr, input logic pin);
        int   ones;
        logic p;
        @(negedge clk);
        rst = r; data_in = d; in_valid = v; odd_sel = odd; acc_clear = clr;
`ifdef PARITY_GEN_CHECK_EN
        parity_in = pin;
`endif
        @(posedge clk);
        #1;
        ones = $countones(d);
        p    = ((ones % 2) == 1) ^ odd;
        if (r) begin
            m_dout = '0; m_par = 0; m_cnt = 0; m_vld = 0; m_acc = 0; m_err = 0; m_sticky = 0;
        end else begin
            m_vld = v;
            if (v) begin
                m_dout = d; m_par = p; m_cnt = ones; m_err = (p != pin);
            end
            if (clr) m_acc = v ? p : 1'b0;
            else if (v) m_acc = m_acc ^ p;
            if (v && (p != pin)) m_sticky = 1'b1;
            else if (clr) m_sticky = 1'b0;
        end
        chk("out_valid", 64'(out_valid), 64'(m_vld));
        chk("data_out", 64'(data_out), 64'(m_dout));
        chk("parity", 64'(parity), 64'(m_par));
        chk("ones_count", 64'(ones_count), 64'(m_cnt));
        chk("acc_parity", 64'(acc_parity), 64'(m_acc));
`ifdef PARITY_GEN_CHECK_EN
        chk("parity_err", 64'(parity_err), 64'(m_err));
        chk("err_sticky", 64'(err_sticky), 64'(m_sticky));
`endif
    endtask

    logic [DATA_W-1:0] tbl [7] = '{8'h00, 8'h01, 8'h03, 8'h80, 8'hDF, 8'h55, 8'hAA};
    logic              even_exp [7] = '{0, 1, 0, 1, 1, 0, 0};
    int                cnt_exp [7]  = '{0, 1, 2, 1, 7, 4, 4};

    initial begin
        // Reset held two cycles with a live all-ones word on the input.
        step(1, 8'hFF, 1, 0, 0, 0);
        chk("rst_valid0", 64'(out_valid), 64'd0);
        step(1, 8'hFF, 1, 0, 0, 0);
        chk("rst_valid1", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(data_out), 64'd0);
        chk("rst_cnt", 64'(ones_count), 64'd0);
        chk("rst_acc", 64'(acc_parity), 64'd0);
        step(0, 8'h00, 0, 0, 0, 0);

        // Even then odd parity tables.
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 7; i++) begin
                step(0, tbl[i], 1, m[0], 0, 0);
                chk($sformatf("tbl_par_m%0d_%0d", m, i), 64'(parity), 64'(even_exp[i] ^ m[0]));
                chk($sformatf("tbl_cnt_m%0d_%0d", m, i), 64'(ones_count), 64'(cnt_exp[i]));
            end
        end

        // Valid gap: one pulse, then held outputs.
        step(0, 8'h81, 1, 0, 0, 0);
        chk("gap_pulse", 64'(out_valid), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step(0, DATA_W'($urandom), 0, 1, 0, 0);
            chk("gap_valid", 64'(out_valid), 64'd0);
            chk("gap_hold", 64'(data_out), 64'h81);
            chk("gap_par", 64'(parity), 64'd0);
        end
        step(0, 8'hFF, 1, 0, 0, 0);
        chk("all_ones_cnt", 64'(ones_count), 64'd8);

        // Stream accumulator.
        step(0, 8'h00, 0, 0, 1, 0);
        chk("acc_clr0", 64'(acc_parity), 64'd0);
        step(0, 8'h01, 1, 0, 0, 0);
        chk("acc_a", 64'(acc_parity), 64'd1);
        step(0, 8'h03, 1, 0, 0, 0);
        chk("acc_b", 64'(acc_parity), 64'd1);
        step(0, 8'h80, 1, 0, 0, 0);
        chk("acc_c", 64'(acc_parity), 64'd0);
        step(0, 8'h01, 1, 0, 0, 0);
        step(0, 8'h01, 1, 0, 1, 0);
        chk("acc_clr_word", 64'(acc_parity), 64'd1);
        step(0, 8'h00, 0, 0, 1, 0);
        chk("acc_clr_alone", 64'(acc_parity), 64'd0);

`ifdef PARITY_GEN_CHECK_EN
        step(0, 8'h01, 1, 0, 0, 1);
        chk("chk_ok", 64'(parity_err), 64'd0);
        step(0, 8'h01, 1, 0, 0, 0);
        chk("chk_err", 64'(parity_err), 64'd1);
        chk("chk_sticky", 64'(err_sticky), 64'd1);
        step(0, 8'h01, 1, 0, 0, 1);
        chk("chk_sticky_hold", 64'(err_sticky), 64'd1);
        step(0, 8'h00, 0, 0, 1, 0);
        chk("chk_sticky_clr", 64'(err_sticky), 64'd0);
`endif

        // Random traffic with occasional reset and clear.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), DATA_W'($urandom), 1'($urandom_range(0, 3) != 0),
                 1'($urandom), ($urandom_range(0, 9) == 0), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
